// File: rtl/tmds_channel_encoder.sv
// Multi-lane TMDS symbol encoder: video 8b/10b with DC balance, control, TERC4 and guard bands.
// Stage 1 holds the freshly encoded symbol; later stages are pure delay for retiming.
module tmds_channel_encoder #(
  parameter int NUM_CH      = 3,
  parameter int PIPE_STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   gb_sel,
  input  logic [8*NUM_CH-1:0]    din,
  input  logic [2*NUM_CH-1:0]    ctrl,
  input  logic [4*NUM_CH-1:0]    aux,
  output logic [10*NUM_CH-1:0]   dout
);

  localparam logic [1:0] MODE_CTRL  = 2'd0;
  localparam logic [1:0] MODE_VIDEO = 2'd1;
  localparam logic [1:0] MODE_TERC4 = 2'd2;
  localparam logic [1:0] MODE_GUARD = 2'd3;

  localparam logic [9:0] SYM_RESET = 10'b1101010100;
  localparam logic [9:0] GB_EVEN   = 10'b1011001100;
  localparam logic [9:0] GB_ODD    = 10'b0100110011;

  if (PIPE_STAGES < 1) begin : g_bad_pipe
    $error("tmds_channel_encoder: PIPE_STAGES must be at least 1");
  end
  if (NUM_CH < 1) begin : g_bad_lanes
    $error("tmds_channel_encoder: NUM_CH must be at least 1");
  end

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      2'b11:   s = 10'b1010101011;
      default: s = 10'b1101010100;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] a);
    logic [9:0] s;
    case (a)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      4'hF:    s = 10'b1011000011;
      default: s = 10'b1010011100;
    endcase
    return s;
  endfunction

  // Returns {updated disparity, symbol}; diff is n1-n0 of q_m[7:0], i.e. 2*n1-8.
  function automatic logic [15:0] video_enc(input logic [7:0] d, input logic signed [5:0] cnt);
    logic [8:0]        qm;
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              use_xnor;
    logic signed [5:0] diff;
    logic signed [5:0] cnt_n;
    logic [9:0]        sym;
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    qm = 9'd0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
    diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    if ((cnt == 6'sd0) || (n1q == 4'd4)) begin
      sym   = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 6'sd0) && (n1q > 4'd4)) || ((cnt < 6'sd0) && (n1q < 4'd4))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt - diff + (qm[8] ? 6'sd2 : 6'sd0);
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt + diff - (qm[8] ? 6'sd0 : 6'sd2);
    end
    return {cnt_n, sym};
  endfunction

  logic [10*NUM_CH-1:0] sym_d;
  logic signed [5:0]    cnt_d [NUM_CH];
  logic signed [5:0]    cnt_q [NUM_CH];
  logic [10*NUM_CH-1:0] pipe_d [PIPE_STAGES];
  logic [10*NUM_CH-1:0] pipe_q [PIPE_STAGES];

  // Per-lane symbol selection; disparity only survives consecutive video cycles.
  always_comb begin
    logic [15:0] venc;
    venc  = 16'd0;
    sym_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = 6'sd0;
      case (mode)
        MODE_CTRL:  sym_d[10*k +: 10] = ctrl_sym(ctrl[2*k +: 2]);
        MODE_VIDEO: begin
          venc              = video_enc(din[8*k +: 8], cnt_q[k]);
          sym_d[10*k +: 10] = venc[9:0];
          cnt_d[k]          = $signed(venc[15:10]);
        end
        MODE_TERC4: sym_d[10*k +: 10] = terc4_sym(aux[4*k +: 4]);
        MODE_GUARD: begin
          if (gb_sel && (k == 0)) begin
            sym_d[10*k +: 10] = terc4_sym(aux[3:0]);
          end else if (gb_sel || ((k % 2) == 1)) begin
            sym_d[10*k +: 10] = GB_ODD;
          end else begin
            sym_d[10*k +: 10] = GB_EVEN;
          end
        end
        default:    sym_d[10*k +: 10] = SYM_RESET;
      endcase
    end
  end

  // Output delay line fed by the stage-1 symbol.
  always_comb begin
    pipe_d[0] = sym_d;
    for (int s = 1; s < PIPE_STAGES; s++) pipe_d[s] = pipe_q[s-1];
  end

  // State registers; reset flushes in-flight symbols to control-00.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= 6'sd0;
      for (int s = 0; s < PIPE_STAGES; s++) pipe_q[s] <= {NUM_CH{SYM_RESET}};
    end else begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
      for (int s = 0; s < PIPE_STAGES; s++) pipe_q[s] <= pipe_d[s];
    end
  end

  assign dout = pipe_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed bench for tmds_channel_encoder: a 3-lane/3-stage instance and a 4-lane/1-stage instance.
module tb_tmds_channel_encoder;

  localparam logic [9:0] C00  = 10'b1101010100;
  localparam logic [9:0] C01  = 10'b0010101011;
  localparam logic [9:0] C10  = 10'b0101010100;
  localparam logic [9:0] C11  = 10'b1010101011;
  localparam logic [9:0] V00A = 10'b0100000000;
  localparam logic [9:0] V00B = 10'b1111111111;
  localparam logic [9:0] GBE  = 10'b1011001100;
  localparam logic [9:0] GBO  = 10'b0100110011;
  localparam logic [9:0] T0   = 10'b1010011100;
  localparam logic [9:0] T8   = 10'b1011001100;
  localparam logic [9:0] TC   = 10'b1010001110;

  logic        clk;
  int          n_tests;
  int          n_fail;

  logic        rst_a;
  logic [1:0]  mode_a;
  logic        gb_a;
  logic [23:0] din_a;
  logic [5:0]  ctrl_a;
  logic [11:0] aux_a;
  logic [29:0] dout_a;

  logic        rst_b;
  logic [1:0]  mode_b;
  logic        gb_b;
  logic [31:0] din_b;
  logic [7:0]  ctrl_b;
  logic [15:0] aux_b;
  logic [39:0] dout_b;

  logic [29:0] ep_a [3];
  string       et_a [3];

  tmds_channel_encoder #(.NUM_CH(3), .PIPE_STAGES(3)) dut_a (
    .clk(clk), .rst(rst_a), .mode(mode_a), .gb_sel(gb_a),
    .din(din_a), .ctrl(ctrl_a), .aux(aux_a), .dout(dout_a)
  );

  tmds_channel_encoder #(.NUM_CH(4), .PIPE_STAGES(1)) dut_b (
    .clk(clk), .rst(rst_b), .mode(mode_b), .gb_sel(gb_b),
    .din(din_b), .ctrl(ctrl_b), .aux(aux_b), .dout(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One cycle on the 3-stage instance; e is the hand-computed symbol for these inputs.
  task automatic step_a(input logic r, input logic [1:0] m, input logic g, input logic [23:0] d,
                        input logic [5:0] c, input logic [11:0] x, input logic [29:0] e,
                        input string tag);
    rst_a = r; mode_a = m; gb_a = g; din_a = d; ctrl_a = c; aux_a = x;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        ep_a[i] = {3{C00}};
        et_a[i] = {"reset/", tag};
      end
    end else begin
      ep_a[2] = ep_a[1]; et_a[2] = et_a[1];
      ep_a[1] = ep_a[0]; et_a[1] = et_a[0];
      ep_a[0] = e;       et_a[0] = tag;
    end
    check_eq(et_a[2], {10'd0, dout_a}, {10'd0, ep_a[2]});
  endtask

  // One cycle on the single-stage instance: result is visible right after the edge.
  task automatic step_b(input logic r, input logic [1:0] m, input logic g, input logic [31:0] d,
                        input logic [15:0] x, input logic [39:0] e, input string tag);
    rst_b = r; mode_b = m; gb_b = g; din_b = d; ctrl_b = 8'd0; aux_b = x;
    @(posedge clk);
    #1;
    check_eq(tag, dout_b, r ? {4{C00}} : e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_a = 1'b1; mode_a = 2'd0; gb_a = 1'b0; din_a = 24'd0; ctrl_a = 6'd0; aux_a = 12'd0;
    rst_b = 1'b1; mode_b = 2'd0; gb_b = 1'b0; din_b = 32'd0; ctrl_b = 8'd0; aux_b = 16'd0;

    step_a(1'b1, 2'd1, 1'b0, 24'hA53C7E, 6'b101101, 12'h9F3, {3{C00}}, "rst0");
    step_a(1'b1, 2'd2, 1'b1, 24'h3CA57E, 6'b011011, 12'h3F9, {3{C00}}, "rst1");
    step_a(1'b0, 2'd0, 1'b0, 24'h000000, 6'b000011, 12'h000, {C00, C00, C11}, "ctrl11");
    step_a(1'b0, 2'd1, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{V00A}}, "vid0_a");
    step_a(1'b0, 2'd1, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{V00B}}, "vid0_b");
    step_a(1'b0, 2'd0, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{C00}}, "ctrl00");
    step_a(1'b0, 2'd1, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{V00A}}, "clr_ctrl");
    step_a(1'b1, 2'd1, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{C00}}, "rst_mid");
    step_a(1'b0, 2'd1, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{V00A}}, "clr_rst");
    step_a(1'b0, 2'd0, 1'b0, 24'h000000, 6'b100100, 12'h000, {C10, C01, C00}, "ctrl_all");
    step_a(1'b0, 2'd1, 1'b0, 24'hF0FF0F, 6'b000000, 12'h000,
           {10'b1000000101, 10'b1000000000, 10'b0100000101}, "vid_mix_a");
    step_a(1'b0, 2'd1, 1'b0, 24'hF0FF0F, 6'b000000, 12'h000,
           {10'b0011111010, 10'b0011111111, 10'b1111111010}, "vid_mix_b");
    step_a(1'b0, 2'd2, 1'b0, 24'h000000, 6'b000000, 12'h0C8, {T0, TC, T8}, "terc4_a");
    step_a(1'b0, 2'd2, 1'b0, 24'h000000, 6'b000000, 12'h75F,
           {10'b0100111100, 10'b0100011110, 10'b1011000011}, "terc4_b");
    step_a(1'b0, 2'd1, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{V00A}}, "vid_after_terc");
    step_a(1'b0, 2'd3, 1'b0, 24'h000000, 6'b000000, 12'h000, {GBE, GBO, GBE}, "guard_vid");
    step_a(1'b0, 2'd3, 1'b1, 24'h000000, 6'b000000, 12'h33C, {GBO, GBO, TC}, "guard_di");
    step_a(1'b0, 2'd0, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{C00}}, "flush0");
    step_a(1'b0, 2'd0, 1'b0, 24'h000000, 6'b000000, 12'h000, {3{C00}}, "flush1");

    step_b(1'b1, 2'd1, 1'b0, 32'hDEADBEEF, 16'h0000, {4{C00}}, "b_rst");
    step_b(1'b0, 2'd3, 1'b0, 32'h00000000, 16'h0000, {GBO, GBE, GBO, GBE}, "b_guard_vid");
    step_b(1'b0, 2'd3, 1'b1, 32'h00000000, 16'h000C, {GBO, GBO, GBO, TC}, "b_guard_di");
    step_b(1'b0, 2'd1, 1'b0, 32'h00000000, 16'h0000, {4{V00A}}, "b_vid0_a");
    step_b(1'b0, 2'd1, 1'b0, 32'h00000000, 16'h0000, {4{V00B}}, "b_vid0_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
